// File: rtl/operand_serializer.sv
// Buffers {sel, A, B} operand pairs in a 2-entry FIFO and streams each pair
// downstream as four nibble pairs, followed by optional hold and gap phases.
module operand_serializer #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_sel,
    output logic [3:0]  nib_a,
    output logic [3:0]  nib_b,
    output logic        sel_out,
    output logic        load_en,
    output logic        busy,
    output logic [7:0]  frames_sent
);

    // state | meaning
    // IDLE  | waiting for a buffered pair; pops the FIFO head when one exists
    // SHIFT | 4 cycles of operand nibbles, least significant first, load_en=1
    // HOLD  | HOLD_CYCLES cycles of zero nibbles with load_en=1
    // GAP   | GAP_CYCLES cycles with load_en=0 while the consumer answers
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    localparam logic [3:0] HOLD_LOAD = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [32:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic [32:0] head;

    state_t      state;
    logic [3:0]  phase;
    logic [11:0] sh_a;
    logic [11:0] sh_b;

    assign in_ready = (count < 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != 2'd0);
    assign head     = fifo_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {in_sel, in_a, in_b};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 4'd0;
            sh_a        <= 12'd0;
            sh_b        <= 12'd0;
            nib_a       <= 4'd0;
            nib_b       <= 4'd0;
            sel_out     <= 1'b0;
            load_en     <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= SHIFT;
                        phase   <= 4'd3;
                        sel_out <= head[32];
                        nib_a   <= head[19:16];
                        sh_a    <= head[31:20];
                        nib_b   <= head[3:0];
                        sh_b    <= head[15:4];
                        load_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (phase != 4'd0) begin
                        phase <= phase - 4'd1;
                        nib_a <= sh_a[3:0];
                        nib_b <= sh_b[3:0];
                        sh_a  <= sh_a >> 4;
                        sh_b  <= sh_b >> 4;
                    end else begin
                        nib_a <= 4'd0;
                        nib_b <= 4'd0;
                        if (HOLD_CYCLES > 0) begin
                            state   <= HOLD;
                            phase   <= HOLD_LOAD;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            phase   <= GAP_LOAD;
                            load_en <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            phase       <= 4'd0;
                            load_en     <= 1'b0;
                            busy        <= 1'b0;
                            frames_sent <= frames_sent + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (phase != 4'd0) begin
                        phase <= phase - 4'd1;
                    end else if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        phase   <= GAP_LOAD;
                        load_en <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        phase       <= 4'd0;
                        load_en     <= 1'b0;
                        busy        <= 1'b0;
                        frames_sent <= frames_sent + 8'd1;
                    end
                end
                GAP: begin
                    if (phase != 4'd0) begin
                        phase <= phase - 4'd1;
                    end else begin
                        state       <= IDLE;
                        phase       <= 4'd0;
                        busy        <= 1'b0;
                        frames_sent <= frames_sent + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Directed checks of operand_serializer: default timing, buffering, reset
// abort, zero hold/gap framing and frame counter wrap.
module tb_operand_serializer;

    logic        clock;
    logic        reset, in_valid, in_sel;
    logic [15:0] in_a, in_b;
    logic        in_ready, sel_out, load_en, busy;
    logic [3:0]  nib_a, nib_b;
    logic [7:0]  frames_sent;

    logic        reset0, in_valid0, in_sel0;
    logic [15:0] in_a0, in_b0;
    logic        in_ready0, sel_out0, load_en0, busy0;
    logic [3:0]  nib_a0, nib_b0;
    logic [7:0]  frames_sent0;

    int total = 0;
    int bad   = 0;

    operand_serializer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .nib_a(nib_a), .nib_b(nib_b),
        .sel_out(sel_out), .load_en(load_en), .busy(busy), .frames_sent(frames_sent)
    );

    operand_serializer #(.HOLD_CYCLES(0), .GAP_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .in_sel(in_sel0), .nib_a(nib_a0), .nib_b(nib_b0),
        .sel_out(sel_out0), .load_en(load_en0), .busy(busy0), .frames_sent(frames_sent0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] ea [6];
        logic [3:0] eb [6];
        logic       zl [11];
        logic [3:0] zn [11];
        int         highs;

        ea = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0};
        eb = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h0, 4'h0};
        zl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        zn = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'h0};

        reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_a = 16'h0; in_b = 16'h0;
        reset0 = 1'b1; in_valid0 = 1'b0; in_sel0 = 1'b0; in_a0 = 16'h0; in_b0 = 16'h0;
        repeat (3) tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_load_en", load_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_sel_out", sel_out, 0);
        chk("rst_nibs", {nib_a, nib_b}, 0);
        chk("rst0_in_ready", in_ready0, 1);
        chk("rst0_load_en", load_en0, 0);
        reset = 1'b0; reset0 = 1'b0;

        // single frame with default hold/gap
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'hABCD; in_sel = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_edge0_load_en", load_en, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t1_load_en_%0d", i + 1), load_en, 1);
            chk($sformatf("t1_nib_a_%0d", i + 1), nib_a, ea[i]);
            chk($sformatf("t1_nib_b_%0d", i + 1), nib_b, eb[i]);
            chk($sformatf("t1_sel_%0d", i + 1), sel_out, 1);
        end
        for (int i = 7; i <= 10; i++) begin
            tick();
            chk($sformatf("t1_gap_load_en_%0d", i), load_en, 0);
            chk($sformatf("t1_gap_nibs_%0d", i), {nib_a, nib_b}, 0);
            chk($sformatf("t1_gap_frames_%0d", i), frames_sent, 0);
            chk($sformatf("t1_gap_busy_%0d", i), busy, 1);
        end
        tick();
        chk("t1_frames_done", frames_sent, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_sel_held", sel_out, 1);

        // three pairs back to back; push and pop coincide on the second edge
        in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0009; in_sel = 1'b0;
        tick();
        chk("t2_ready_e0", in_ready, 1);
        in_a = 16'h0006; in_b = 16'h0008; in_sel = 1'b1;
        tick();
        chk("t2_ready_pushpop", in_ready, 1);
        chk("t2_p1_load_en", load_en, 1);
        chk("t2_p1_nib_a", nib_a, 4'h5);
        chk("t2_p1_nib_b", nib_b, 4'h9);
        chk("t2_p1_sel", sel_out, 0);
        in_a = 16'h0007; in_b = 16'h0003; in_sel = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t2_ready_full", in_ready, 0);
        repeat (9) tick();
        chk("t2_ready_full_e11", in_ready, 0);
        chk("t2_frames_e11", frames_sent, 2);
        chk("t2_idle_gap_e11", load_en, 0);
        tick();
        chk("t2_p2_nib_a", nib_a, 4'h6);
        chk("t2_p2_nib_b", nib_b, 4'h8);
        chk("t2_p2_sel", sel_out, 1);
        chk("t2_ready_after_pop", in_ready, 1);
        repeat (10) tick();
        chk("t2_frames_e22", frames_sent, 3);
        tick();
        chk("t2_p3_nib_a", nib_a, 4'h7);
        chk("t2_p3_nib_b", nib_b, 4'h3);
        chk("t2_p3_sel", sel_out, 0);
        chk("t2_p3_load_en", load_en, 1);
        repeat (11) tick();
        chk("t2_frames_end", frames_sent, 4);
        chk("t2_busy_end", busy, 0);

        // reset after two nibbles with one pair still buffered
        in_valid = 1'b1; in_a = 16'hFEDC; in_b = 16'h1357; in_sel = 1'b1;
        tick();
        in_a = 16'h1111; in_b = 16'h2222; in_sel = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t3_nib_a_0", nib_a, 4'hC);
        chk("t3_nib_b_0", nib_b, 4'h7);
        tick();
        chk("t3_nib_a_1", nib_a, 4'hD);
        chk("t3_nib_b_1", nib_b, 4'h5);
        reset = 1'b1; in_valid = 1'b1; in_a = 16'h9999; in_b = 16'h9999;
        tick();
        chk("t3_rst_load_en", load_en, 0);
        chk("t3_rst_busy", busy, 0);
        chk("t3_rst_ready", in_ready, 1);
        chk("t3_rst_frames", frames_sent, 0);
        chk("t3_rst_sel", sel_out, 0);
        chk("t3_rst_nibs", {nib_a, nib_b}, 0);
        reset = 1'b0; in_valid = 1'b0;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (load_en || busy) highs++;
        end
        chk("t3_no_more_nibbles", highs, 0);
        chk("t3_fifo_empty_ready", in_ready, 1);
        chk("t3_frames_after", frames_sent, 0);

        // zero hold and gap: 4-cycle frames separated by one idle cycle
        in_valid0 = 1'b1; in_a0 = 16'h4321; in_b0 = 16'h8765; in_sel0 = 1'b1;
        tick();
        in_a0 = 16'hCBA9; in_b0 = 16'h0FED; in_sel0 = 1'b0;
        tick();
        in_valid0 = 1'b0;
        chk("t4_sel_f1", sel_out0, 1);
        chk("t4_nib_b_f1", nib_b0, 4'h5);
        for (int i = 0; i < 11; i++) begin
            if (i != 0) tick();
            chk($sformatf("t4_load_en_%0d", i + 1), load_en0, zl[i]);
            chk($sformatf("t4_nib_a_%0d", i + 1), nib_a0, zn[i]);
            if (i == 4) chk("t4_frames_f1", frames_sent0, 1);
            if (i == 5) chk("t4_sel_f2", sel_out0, 0);
            if (i == 9) chk("t4_frames_f2", frames_sent0, 2);
        end

        // counter wrap after 256 frames
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        in_valid0 = 1'b1; in_a0 = 16'h5A5A; in_b0 = 16'hA5A5; in_sel0 = 1'b1;
        for (int e = 0; e <= 1280; e++) begin
            tick();
            if (e == 5)    chk("t5_frames_1", frames_sent0, 1);
            if (e == 1275) chk("t5_frames_255", frames_sent0, 255);
            if (e == 1280) chk("t5_frames_wrap", frames_sent0, 0);
        end
        in_valid0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
